// File: rtl/ow_slot_scheduler.sv
// Round-robin owner of the shared one-wire ID UART: grants one slot at a time, then
// parks the select for a guard interval. Optional grant timeout: `OW_SCHED_TIMEOUT_EN`.
module ow_slot_scheduler #(
    parameter int NUM_SLOTS          = 7,
    parameter int UART_ADDRESS_WIDTH = 4,
    parameter int SLOT_OFFSET        = 7,
    parameter int PARK_ADDR          = 0,
    parameter int GUARD_TICKS        = 4,
    parameter int TIMEOUT_TICKS      = 200
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          tick,
    input  logic [NUM_SLOTS-1:0]          slot_mask,
    input  logic [NUM_SLOTS-1:0]          req,
    input  logic [NUM_SLOTS-1:0]          done,
    output logic [NUM_SLOTS-1:0]          grant,
    output logic [UART_ADDRESS_WIDTH-1:0] uart_slot_en,
    output logic                          busy,
    output logic                          timeout_pulse,
    output logic [$clog2(NUM_SLOTS)-1:0]  timeout_slot
);
    localparam int SLOT_W  = $clog2(NUM_SLOTS);
    localparam int CNT_TOP = (TIMEOUT_TICKS > GUARD_TICKS) ? TIMEOUT_TICKS : GUARD_TICKS;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0]              CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]              GUARD_C   = CNT_W'(GUARD_TICKS);
    localparam logic [SLOT_W-1:0]             LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [UART_ADDRESS_WIDTH-1:0] PARK_C    = UART_ADDRESS_WIDTH'(PARK_ADDR);
    localparam logic [NUM_SLOTS-1:0]          ONE_C     = NUM_SLOTS'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [NUM_SLOTS-1:0]          grant_q, grant_d;
    logic [UART_ADDRESS_WIDTH-1:0] uart_q, uart_d;
    logic                          busy_q, busy_d;
    logic                          tpulse_q, tpulse_d;
    logic [SLOT_W-1:0]             tslot_q, tslot_d;
    logic [SLOT_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [SLOT_W-1:0]             owner_q, owner_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    logic [NUM_SLOTS-1:0] elig_s;
    logic                 elig_any_s;
    logic [SLOT_W-1:0]    lo_pick_s, hi_pick_s, winner_s;
    logic                 hi_found_s;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic                 owner_rel_s, timeout_hit_s, release_s, guard_done_s;

    assign elig_s       = req & slot_mask;
    assign elig_any_s   = |elig_s;
    assign cnt_inc_s    = (tick && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_W'(1)) : cnt_q;
    assign owner_rel_s  = done[owner_q] | ~req[owner_q] | ~slot_mask[owner_q];
    assign guard_done_s = (cnt_inc_s >= GUARD_C);
    assign release_s    = owner_rel_s | timeout_hit_s;

`ifdef OW_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_TICKS);
    // A normal release in the same cycle pre-empts the timeout so no pulse is reported.
    assign timeout_hit_s = (state_q == ST_GRANT) && !owner_rel_s && (cnt_inc_s >= TIMEOUT_C);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Round-robin pick: lowest eligible index at/after rr_ptr, else lowest overall.
    always_comb begin
        lo_pick_s  = '0;
        hi_pick_s  = '0;
        hi_found_s = 1'b0;
        for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
            lo_pick_s = elig_s[j] ? SLOT_W'(j) : lo_pick_s;
            if (elig_s[j] && (j >= int'(rr_ptr_q))) begin
                hi_pick_s  = SLOT_W'(j);
                hi_found_s = 1'b1;
            end else begin
                hi_pick_s  = hi_pick_s;
                hi_found_s = hi_found_s;
            end
        end
        winner_s = hi_found_s ? hi_pick_s : lo_pick_s;
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            uart_q   <= PARK_C;
            busy_q   <= 1'b0;
            tpulse_q <= 1'b0;
            tslot_q  <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            uart_q   <= uart_d;
            busy_q   <= busy_d;
            tpulse_q <= tpulse_d;
            tslot_q  <= tslot_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = elig_any_s   ? ST_GRANT : ST_IDLE;
            ST_GRANT: state_d = release_s    ? ST_GUARD : ST_GRANT;
            ST_GUARD: state_d = guard_done_s ? ST_IDLE  : ST_GUARD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        grant_d  = grant_q;
        uart_d   = uart_q;
        busy_d   = busy_q;
        tpulse_d = 1'b0;
        tslot_d  = tslot_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (elig_any_s) begin
                    grant_d = ONE_C << winner_s;
                    uart_d  = UART_ADDRESS_WIDTH'(SLOT_OFFSET + int'(winner_s));
                    owner_d = winner_s;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    grant_d = '0;
                    uart_d  = PARK_C;
                    busy_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                busy_d = 1'b1;
                if (release_s) begin
                    grant_d  = '0;
                    uart_d   = PARK_C;
                    rr_ptr_d = (owner_q == LAST_SLOT) ? '0 : (owner_q + SLOT_W'(1));
                    cnt_d    = '0;
                    tpulse_d = timeout_hit_s;
                    tslot_d  = timeout_hit_s ? owner_q : tslot_q;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_GUARD: begin
                if (guard_done_s) begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    busy_d = 1'b1;
                    cnt_d  = cnt_inc_s;
                end
            end
            default: begin
                grant_d = '0;
                uart_d  = PARK_C;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign grant         = grant_q;
    assign uart_slot_en  = uart_q;
    assign busy          = busy_q;
    assign timeout_pulse = tpulse_q;
    assign timeout_slot  = tslot_q;

endmodule

// File: tb/tb_ow_slot_scheduler.sv
// Scoreboard bench for ow_slot_scheduler: expected owners are queued when requests are
// driven and popped when a grant appears.
module tb_ow_slot_scheduler;
    logic       clk;
    logic       resetn;
    logic       tick;
    logic [6:0] slot_mask;
    logic [6:0] req;
    logic [6:0] done;
    logic [6:0] grant;
    logic [3:0] uart_slot_en;
    logic       busy;
    logic       timeout_pulse;
    logic [2:0] timeout_slot;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int tick_div = 0;

    ow_slot_scheduler dut (
        .clk(clk), .resetn(resetn), .tick(tick), .slot_mask(slot_mask),
        .req(req), .done(done), .grant(grant), .uart_slot_en(uart_slot_en),
        .busy(busy), .timeout_pulse(timeout_pulse), .timeout_slot(timeout_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tick: one clk wide, every 4th clk, changes just after posedge so it is stable at negedge
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_div = (tick_div == 3) ? 0 : tick_div + 1;
            tick = (tick_div == 0);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0; req = 7'd0; done = 7'd0; slot_mask = 7'h7F;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (grant != 7'd0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if ({grant, uart_slot_en, busy, timeout_pulse, timeout_slot} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant=%b uart=%0d busy=%b tp=%b ts=%0d, expected all 0",
                     grant, uart_slot_en, busy, timeout_pulse, timeout_slot);
        end
    endtask

    task automatic test_single();
        int exp, ticks;
        bit ok;
        apply_reset();
        @(negedge clk);
        req = 7'b0000100; exp_q.push_back(2);
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++;
        if (grant !== 7'(1 << exp) || uart_slot_en !== 4'(7 + exp) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got grant=%b uart=%0d busy=%b, expected grant=%b uart=%0d busy=1",
                     grant, uart_slot_en, busy, 7'(1 << exp), 7 + exp);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (grant !== 7'b0000100) begin
            n_fail++; $display("FAIL single_hold: got grant=%b, expected 0000100", grant);
        end
        done = 7'b0000100; req = 7'd0;
        @(negedge clk);
        done = 7'd0;
        n_checks++;
        if (grant !== 7'd0 || uart_slot_en !== 4'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_release: got grant=%b uart=%0d busy=%b, expected 0/0/1",
                     grant, uart_slot_en, busy);
        end
        ticks = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            if (tick) ticks++;
            @(negedge clk);
        end
        n_checks++;
        if (!ok || ticks != 4) begin
            n_fail++; $display("FAIL single_guard_ticks: got %0d ticks (idle=%b), expected 4", ticks, ok);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        bit ok;
        apply_reset();
        @(negedge clk);
        req = 7'b1010010;
        exp_q.push_back(1); exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(1);
        for (int k = 0; k < 4; k++) begin
            wait_grant(ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || grant !== 7'(1 << exp) || uart_slot_en !== 4'(7 + exp)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got grant=%b uart=%0d, expected grant=%b uart=%0d",
                         k, grant, uart_slot_en, 7'(1 << exp), 7 + exp);
            end
            repeat (3) @(negedge clk);
            done = 7'(1 << exp);
            @(negedge clk);
            done = 7'd0;
            n_checks++;
            if (grant !== 7'd0 || uart_slot_en !== 4'd0) begin
                n_fail++;
                $display("FAIL rr_park%0d: got grant=%b uart=%0d, expected 0/0", k, grant, uart_slot_en);
            end
        end
        req = 7'd0;
        wait_idle(ok);
    endtask

    task automatic test_masking();
        int exp;
        bit ok;
        apply_reset();
        @(negedge clk);
        slot_mask = 7'b0001000; req = 7'h7F; exp_q.push_back(3);
        wait_grant(ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || grant !== 7'(1 << exp) || uart_slot_en !== 4'(7 + exp)) begin
            n_fail++;
            $display("FAIL mask_grant: got grant=%b uart=%0d, expected grant=%b uart=%0d",
                     grant, uart_slot_en, 7'(1 << exp), 7 + exp);
        end
        repeat (2) @(negedge clk);
        slot_mask = 7'd0;
        @(negedge clk);
        n_checks++;
        if (grant !== 7'd0 || uart_slot_en !== 4'd0) begin
            n_fail++;
            $display("FAIL mask_loss_release: got grant=%b uart=%0d, expected 0/0", grant, uart_slot_en);
        end
        wait_idle(ok);
        repeat (20) @(negedge clk);
        n_checks++;
        if (!ok || grant !== 7'd0 || uart_slot_en !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_stay_idle: got grant=%b uart=%0d busy=%b, expected 0/0/0",
                     grant, uart_slot_en, busy);
        end
        req = 7'd0; slot_mask = 7'h7F;
    endtask

    task automatic test_foreign_done();
        int exp;
        bit ok;
        apply_reset();
        @(negedge clk);
        req = 7'b0000100; exp_q.push_back(2);
        wait_grant(ok);
        exp = exp_q.pop_front();
        done = 7'b0000001;
        @(negedge clk);
        done = 7'd0;
        @(negedge clk);
        n_checks++;
        if (!ok || grant !== 7'(1 << exp) || uart_slot_en !== 4'(7 + exp)) begin
            n_fail++;
            $display("FAIL foreign_done: got grant=%b uart=%0d, expected grant=%b uart=%0d",
                     grant, uart_slot_en, 7'(1 << exp), 7 + exp);
        end
        req = 7'd0;
        wait_idle(ok);
    endtask

    task automatic test_reset_mid_grant();
        int exp;
        bit ok;
        apply_reset();
        @(negedge clk);
        req = 7'b0000010;
        wait_grant(ok);
        done = 7'b0000010; req = 7'd0;
        @(negedge clk);
        done = 7'd0;
        wait_idle(ok);
        req = 7'b0010000; exp_q.push_back(4);
        wait_grant(ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || grant !== 7'(1 << exp)) begin
            n_fail++; $display("FAIL rst_pre_grant: got grant=%b, expected %b", grant, 7'(1 << exp));
        end
        req = 7'b0010001;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant !== 7'd0 || uart_slot_en !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_grant: got grant=%b uart=%0d busy=%b, expected 0/0/0",
                     grant, uart_slot_en, busy);
        end
        resetn = 1'b1; exp_q.push_back(0);
        wait_grant(ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || grant !== 7'(1 << exp) || uart_slot_en !== 4'(7 + exp)) begin
            n_fail++;
            $display("FAIL rst_rr_ptr: got grant=%b uart=%0d, expected grant=%b uart=%0d",
                     grant, uart_slot_en, 7'(1 << exp), 7 + exp);
        end
        req = 7'd0;
        wait_idle(ok);
    endtask

`ifdef OW_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int ticks;
        bit ok, seen;
        apply_reset();
        @(negedge clk);
        req = 7'b0100000;
        wait_grant(ok);
        ticks = 0; seen = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (timeout_pulse) begin seen = 1'b1; break; end
            if (tick) ticks++;
            @(negedge clk);
        end
        n_checks++;
        if (!seen || ticks != 200 || timeout_slot !== 3'd5 || grant !== 7'd0) begin
            n_fail++;
            $display("FAIL timeout_fire: got pulse=%b ticks=%0d slot=%0d grant=%b, expected 1/200/5/0",
                     seen, ticks, timeout_slot, grant);
        end
        @(negedge clk);
        n_checks++;
        if (timeout_pulse !== 1'b0) begin
            n_fail++; $display("FAIL timeout_one_cycle: got pulse=%b, expected 0", timeout_pulse);
        end
        req = 7'd0;
        wait_idle(ok);
        apply_reset();
        @(negedge clk);
        req = 7'b0100000;
        wait_grant(ok);
        ticks = 0; seen = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (timeout_pulse) seen = 1'b1;
            if (tick && ticks == 199) begin
                done = 7'b0100000;
                @(negedge clk);
                done = 7'd0;
                break;
            end
            if (tick) ticks++;
            @(negedge clk);
        end
        n_checks++;
        if (seen || timeout_pulse !== 1'b0 || grant !== 7'd0 || timeout_slot !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_done_wins: got pulse=%b early=%b grant=%b slot=%0d, expected 0/0/0/0",
                     timeout_pulse, seen, grant, timeout_slot);
        end
        req = 7'd0;
        wait_idle(ok);
    endtask
`endif

    initial begin
        resetn = 1'b0; req = 7'd0; done = 7'd0; slot_mask = 7'h7F;
        test_reset();
        test_single();
        test_round_robin();
        test_masking();
        test_foreign_done();
        test_reset_mid_grant();
`ifdef OW_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
